// File: rtl/swo_tx.sv
// NRZ Serial Wire Output transmitter: a byte FIFO feeding a UART-style serialiser
// (1 start bit, 8 data bits LSB-first, 1 stop bit) with a per-frame latched bit period.
module swo_tx #(
    parameter int pFIFO_DEPTH = 16,
    parameter int pDIV_WIDTH  = 16
) (
    input  logic                           target_clk,
    input  logic                           reset_n,
    input  logic                           I_enable,
    input  logic [pDIV_WIDTH-1:0]          I_baud_div,
    input  logic [7:0]                     I_data,
    input  logic                           I_wr,
    input  logic                           I_clear_overflow,
    output logic                           O_full,
    output logic                           O_empty,
    output logic [$clog2(pFIFO_DEPTH):0]   O_fifo_count,
    output logic                           O_busy,
    output logic                           O_overflow,
    output logic                           O_swo,
    output logic [1:0]                     O_dbg_state
);
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mem [pFIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic [pDIV_WIDTH-1:0]   div_q, div_d, cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic                    swo_q, swo_d;
    logic                    ovf_q, ovf_d;
    logic                    push, pop, tick, start_ok;

    assign O_full       = (count_q == CW'(pFIFO_DEPTH));
    assign O_empty      = (count_q == '0);
    assign O_fifo_count = count_q;
    assign O_overflow   = ovf_q;
    assign O_swo        = swo_q;
    assign O_dbg_state  = state_q;

    assign push     = I_wr && !O_full;
    assign tick     = (cnt_q == div_q);
    assign start_ok = I_enable && !O_empty;
    // A pop happens exactly when a frame starts, whether from IDLE or straight out of STOP.
    assign pop      = (state_d == S_START) && (state_q == S_IDLE || state_q == S_STOP);

    always_ff @(posedge target_clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_START;
            S_START: if (tick) state_d = S_DATA;
            S_DATA:  if (tick && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:  if (tick) state_d = start_ok ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        swo_d  = 1'b1;
        O_busy = (state_q != S_IDLE);
        case (state_d)
            S_START: swo_d = 1'b0;
            S_DATA:  swo_d = shift_d[0];
            default: swo_d = 1'b1;
        endcase
    end

    // Bit timing datapath; the divider is only relatched at a frame start.
    always_comb begin
        shift_d = shift_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (pop) begin
            shift_d = mem[rd_ptr_q];
            div_d   = I_baud_div;
            cnt_d   = '0;
            bit_d   = '0;
        end else if (state_q != S_IDLE) begin
            if (tick) begin
                cnt_d = '0;
                if (state_q == S_DATA) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (I_wr && O_full)        ovf_d = 1'b1;
        else if (I_clear_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge target_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            swo_q    <= 1'b1;
            shift_q  <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            swo_q   <= swo_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_ff @(posedge target_clk) begin
        if (push) mem[wr_ptr_q] <= I_data;
    end
endmodule

// File: tb/tb_swo_tx.sv
// Directed bench for swo_tx: frames are sampled on falling clock edges and
// checked bit-by-bit against bytes queued in the expected-data scoreboard.
module tb_swo_tx;
    logic        target_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        I_enable = 1'b0;
    logic [15:0] I_baud_div = '0;
    logic [7:0]  I_data = '0;
    logic        I_wr = 1'b0;
    logic        I_clear_overflow = 1'b0;
    logic        O_full, O_empty, O_busy, O_overflow, O_swo;
    logic [4:0]  O_fifo_count;
    logic [1:0]  O_dbg_state;

    logic [7:0]  exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    swo_tx #(.pFIFO_DEPTH(16), .pDIV_WIDTH(16)) dut (
        .target_clk(target_clk), .reset_n(reset_n), .I_enable(I_enable),
        .I_baud_div(I_baud_div), .I_data(I_data), .I_wr(I_wr),
        .I_clear_overflow(I_clear_overflow), .O_full(O_full), .O_empty(O_empty),
        .O_fifo_count(O_fifo_count), .O_busy(O_busy), .O_overflow(O_overflow),
        .O_swo(O_swo), .O_dbg_state(O_dbg_state)
    );

    always #5 target_clk = ~target_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one write strobe for a single clock; accepted bytes go to the scoreboard.
    task automatic wr_byte(input logic [7:0] d, input bit accept);
        I_wr = 1'b1;
        I_data = d;
        @(negedge target_clk);
        I_wr = 1'b0;
        if (accept) exp_q.push_back(d);
    endtask

    // Returns at the first falling edge where the line is low (current edge included).
    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (O_swo !== 1'b0 && waited < budget) begin
            @(negedge target_clk);
            waited++;
        end
        check("start_seen", {31'd0, O_swo === 1'b0}, 32'd1);
    endtask

    // Samples one frame starting with the current falling edge; ends on the last stop-bit edge.
    task automatic sample_frame(input int div, input string tag);
        logic [9:0] bits;
        bit         stable;
        int         busy_cnt;
        logic [7:0] exp;
        stable = 1'b1;
        busy_cnt = 0;
        bits = '0;
        for (int k = 0; k < 10 * (div + 1); k++) begin
            if (k > 0) @(negedge target_clk);
            if (O_busy === 1'b1) busy_cnt++;
            if (k % (div + 1) == 0) bits[k / (div + 1)] = O_swo;
            else if (O_swo !== bits[k / (div + 1)]) stable = 1'b0;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
        check({tag, "_stop"}, {31'd0, bits[9]}, 32'd1);
        check({tag, "_stable"}, {31'd0, stable}, 32'd1);
        check({tag, "_busy"}, busy_cnt, 10 * (div + 1));
        check({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, exp});
    endtask

    initial begin
        int waited;
        bit low_seen;

        // Reset state
        #12;
        check("rst_swo", {31'd0, O_swo}, 32'd1);
        check("rst_busy", {31'd0, O_busy}, 32'd0);
        check("rst_full", {31'd0, O_full}, 32'd0);
        check("rst_empty", {31'd0, O_empty}, 32'd1);
        check("rst_count", {27'd0, O_fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, O_overflow}, 32'd0);
        @(negedge target_clk);
        reset_n = 1'b1;
        @(negedge target_clk);

        // div=0, single byte 0xA5
        I_baud_div = 16'd0;
        I_enable = 1'b1;
        wr_byte(8'hA5, 1'b1);
        check("t1_notempty", {31'd0, O_empty}, 32'd0);
        check("t1_idle_line", {31'd0, O_swo}, 32'd1);
        wait_start(20, waited);
        check("t1_latency", waited, 32'd1);
        sample_frame(0, "t1");
        @(negedge target_clk);
        check("t1_busy_end", {31'd0, O_busy}, 32'd0);
        check("t1_empty_end", {31'd0, O_empty}, 32'd1);

        // div=3, back-to-back 0x00 then 0xFF
        I_baud_div = 16'd3;
        wr_byte(8'h00, 1'b1);
        wr_byte(8'hFF, 1'b1);
        wait_start(20, waited);
        sample_frame(3, "t2a");
        @(negedge target_clk);
        check("t2_no_gap", {31'd0, O_swo}, 32'd0);
        sample_frame(3, "t2b");
        @(negedge target_clk);
        check("t2_busy_end", {31'd0, O_busy}, 32'd0);

        // Fill FIFO with enable low, then overflow
        I_enable = 1'b0;
        for (int i = 0; i < 16; i++) wr_byte(8'(i), 1'b1);
        check("t3_full", {31'd0, O_full}, 32'd1);
        check("t3_count16", {27'd0, O_fifo_count}, 32'd16);
        check("t3_ovf_before", {31'd0, O_overflow}, 32'd0);
        wr_byte(8'h10, 1'b0);
        check("t3_ovf_after", {31'd0, O_overflow}, 32'd1);
        check("t3_count_kept", {27'd0, O_fifo_count}, 32'd16);

        // Clear collides with a dropped write: set wins
        I_clear_overflow = 1'b1;
        wr_byte(8'h11, 1'b0);
        I_clear_overflow = 1'b0;
        check("t4_set_wins", {31'd0, O_overflow}, 32'd1);
        I_clear_overflow = 1'b1;
        @(negedge target_clk);
        I_clear_overflow = 1'b0;
        check("t4_cleared", {31'd0, O_overflow}, 32'd0);

        // Drain the 16 queued bytes back-to-back
        I_baud_div = 16'd0;
        I_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_start(20, waited);
            sample_frame(0, "t3f");
        end
        @(negedge target_clk);
        check("t3_empty_end", {31'd0, O_empty}, 32'd1);
        check("t3_busy_end", {31'd0, O_busy}, 32'd0);

        // Divider change mid-frame
        I_enable = 1'b0;
        wr_byte(8'h3C, 1'b1);
        wr_byte(8'hC3, 1'b1);
        I_baud_div = 16'd1;
        I_enable = 1'b1;
        wait_start(20, waited);
        I_baud_div = 16'd7;
        sample_frame(1, "t5a");
        wait_start(20, waited);
        check("t5_no_gap", waited, 32'd1);
        sample_frame(7, "t5b");
        @(negedge target_clk);

        // Asynchronous reset in the middle of DATA
        I_baud_div = 16'd3;
        wr_byte(8'h55, 1'b1);
        wr_byte(8'h9A, 1'b1);
        wait_start(20, waited);
        repeat (6) @(negedge target_clk);
        check("t6_in_data", {30'd0, O_dbg_state}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_swo", {31'd0, O_swo}, 32'd1);
        check("t6_rst_busy", {31'd0, O_busy}, 32'd0);
        check("t6_rst_count", {27'd0, O_fifo_count}, 32'd0);
        exp_q.delete();
        @(negedge target_clk);
        reset_n = 1'b1;
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge target_clk);
            if (O_swo !== 1'b1 || O_busy !== 1'b0) low_seen = 1'b1;
        end
        check("t6_no_residual", {31'd0, low_seen}, 32'd0);
        check("t6_sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/swo_tx.md
Name: swo_tx

Overview:
- NRZ (UART-style) Serial Wire Output transmitter: the transmit end of the SWO link that the trace capture front end receives on its swo input.
- Buffers bytes in a small FIFO and serialises them LSB-first, with 1 start bit and 1 stop bit, at a programmable bit period.
- Used as a target-side ITM/SWO emulator in benches and FPGA self-test, looping its output back into the capture path.

Parameters:
- pFIFO_DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
- pDIV_WIDTH, 16, width of the bit-period divider.

Ports:
- target_clk  input  1  sole clock; all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- I_enable  input  1  permits starting new frames.
- I_baud_div  input  pDIV_WIDTH  bit period = I_baud_div+1 target_clk cycles.
- I_data  input  8  byte to enqueue.
- I_wr  input  1  enqueue strobe, one byte per cycle.
- I_clear_overflow  input  1  clears O_overflow.
- O_full  output  1  FIFO count == pFIFO_DEPTH.
- O_empty  output  1  FIFO count == 0.
- O_fifo_count  output  $clog2(pFIFO_DEPTH)+1  bytes currently queued.
- O_busy  output  1  FSM not in IDLE.
- O_overflow  output  1  sticky: a write was dropped.
- O_swo  output  1  serial line, registered, idles high.

Behaviour:
- Reset values (asserted asynchronously, held until reset_n rises):
  - O_swo=1, O_busy=0, O_full=0, O_empty=1, O_fifo_count=0, O_overflow=0.
  - FSM in IDLE; FIFO pointers, bit counter and divider counter all 0.
- FIFO write rule:
  - A write is accepted on I_wr && !O_full. O_full is registered; there is no same-cycle bypass.
  - If I_wr is asserted while O_full=1, the byte is dropped and O_overflow is set on the next edge.
- FIFO read:
  - The FSM pops one byte on entry to START.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo pFIFO_DEPTH.
- O_overflow:
  - Cleared by I_clear_overflow.
  - If a set and a clear occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when I_enable && !O_empty.
    - On that edge the FSM pops the head byte into the shift register and latches I_baud_div into div_r.
    - O_swo=0 from that edge.
  - START lasts div_r+1 cycles, then goes to DATA with bit index 0.
  - DATA drives shift[0] for div_r+1 cycles per bit, then shifts right. After bit 7 it goes to STOP.
  - STOP drives O_swo=1 for div_r+1 cycles. At the end of STOP:
    - If I_enable && !O_empty, go directly to START (pop, relatch divider), giving back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Frame length: exactly 10*(div_r+1) cycles.
- Latency: a byte written at edge N into an empty FIFO while in IDLE with enable high gives O_empty=0 after N. The start bit begins at edge N+1.
- A changed I_baud_div takes effect only at the next frame start; a frame in flight is never altered.
- I_baud_div=0 gives 1 cycle per bit, a 10-cycle frame.
- Deasserting I_enable mid-frame has no effect on the current frame. The FSM completes STOP and then idles, with FIFO contents retained.
- O_busy=1 in START, DATA and STOP.
- No parity bit; no break generation.

Test Plan:
- Reset, div=0, enable=1, write 0xA5 -> O_swo sequence 0,1,0,1,0,0,1,0,1,1, one cycle each, starting 1 cycle after the write; O_busy high for exactly 10 cycles; then O_empty=1.
- div=3, write 0x00 and 0xFF back-to-back -> 80 cycles total, each bit held 4 cycles, no idle gap between frames; the stop bit of the first frame is immediately followed by the start bit of the second.
- enable=0, write 17 bytes with depth 16 -> O_full=1 after 16 writes, O_overflow=1 after the 17th. Then enable=1 -> exactly 16 frames, data 0x00..0x0F in order; O_empty=1 at end.
- Pulse I_clear_overflow in the same cycle as a dropped write -> O_overflow stays 1. A clear in a later cycle with no write -> O_overflow=0.
- Change div from 1 to 7 mid-frame -> the current frame keeps 2-cycle bits; the next frame uses 8-cycle bits.
- Assert reset_n=0 mid-DATA -> O_swo=1, O_busy=0, O_fifo_count=0 immediately (asynchronous). After release, no residual frame is transmitted.
